// File: rtl/chipset_pkg.sv
// rtl/chipset_pkg.sv - shared types and default vectors for the chipset reset logic
package chipset_pkg;

    typedef enum logic [1:0] {
        S_POWER_UP,
        S_RELEASE,
        S_RUN,
        S_HOLD
    } state_t;

    localparam logic [15:0] DEFAULT_ROM_VECTOR = 16'h0000;
    localparam logic [15:0] DEFAULT_RAM_VECTOR = 16'h8000;

    // Saturating increment used for the button-reset event counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser plus stability-counter debouncer
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching sample,
    // so the pulses line up with the cycle in which level_out changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            stable_cnt <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_1     <= raw_in;
            sync_2     <= sync_1;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (sync_2 != level_out) begin
                if (stable_cnt == CNT_LAST) begin
                    level_out  <= sync_2;
                    stable_cnt <= '0;
                    rise_pulse <= sync_2;
                    fall_pulse <= ~sync_2;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - power-on sequencer with staggered domain release and boot select
module reset_sequencer
    import chipset_pkg::*;
#(
    parameter int                    DEBOUNCE_CYCLES = 4,
    parameter int                    POWER_UP_CYCLES = 8,
    parameter int                    NUM_DOMAINS     = 2,
    parameter int                    PC_WIDTH        = 16,
    parameter logic [PC_WIDTH-1:0]   ROM_VECTOR      = PC_WIDTH'(DEFAULT_ROM_VECTOR),
    parameter logic [PC_WIDTH-1:0]   RAM_VECTOR      = PC_WIDTH'(DEFAULT_RAM_VECTOR)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reset_button,
    input  logic                   boot_sel,
    input  logic                   ram_switch_req,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   pc_load,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   is_powered_on,
    output logic                   flag_execute_from_ram,
    output logic [7:0]             reset_count
);

    localparam int PW = $clog2(POWER_UP_CYCLES + 1);
    localparam int RW = $clog2(NUM_DOMAINS + 1);
    localparam logic [PW-1:0]          PWR_LAST = PW'(POWER_UP_CYCLES - 1);
    localparam logic [RW-1:0]          REL_LAST = RW'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] ONE_DOM  = NUM_DOMAINS'(1);

    state_t        state;
    logic [PW-1:0] pwr_cnt;
    logic [RW-1:0] rel_cnt;
    logic          deb_level;
    logic          deb_rise;
    logic          deb_fall;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (reset_button),
        .level_out (deb_level),
        .rise_pulse(deb_rise),
        .fall_pulse(deb_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= S_POWER_UP;
            pwr_cnt               <= '0;
            rel_cnt               <= '0;
            domain_reset          <= '1;
            is_powered_on         <= 1'b0;
            flag_execute_from_ram <= 1'b0;
            pc                    <= ROM_VECTOR;
            pc_load               <= 1'b0;
            reset_count           <= 8'd0;
        end else begin
            pc_load <= 1'b0;
            // A button press outranks every other event, including the last
            // release step and a pending RAM switch request.
            if (deb_rise && state != S_HOLD) begin
                state                 <= S_HOLD;
                pwr_cnt               <= '0;
                rel_cnt               <= '0;
                domain_reset          <= '1;
                is_powered_on         <= 1'b0;
                flag_execute_from_ram <= 1'b0;
                pc                    <= ROM_VECTOR;
                reset_count           <= sat_inc8(reset_count);
            end else begin
                case (state)
                    S_POWER_UP: begin
                        if (pwr_cnt == PWR_LAST) begin
                            flag_execute_from_ram <= boot_sel;
                            pc                    <= boot_sel ? RAM_VECTOR : ROM_VECTOR;
                            pwr_cnt               <= '0;
                            rel_cnt               <= '0;
                            state                 <= S_RELEASE;
                        end else begin
                            pwr_cnt <= pwr_cnt + PW'(1);
                        end
                    end
                    S_RELEASE: begin
                        domain_reset <= domain_reset & ~(ONE_DOM << rel_cnt);
                        if (rel_cnt == REL_LAST) begin
                            state         <= S_RUN;
                            is_powered_on <= 1'b1;
                            pc_load       <= 1'b1;
                        end else begin
                            rel_cnt <= rel_cnt + RW'(1);
                        end
                    end
                    S_RUN: begin
                        if (ram_switch_req && !flag_execute_from_ram) begin
                            flag_execute_from_ram <= 1'b1;
                            pc                    <= RAM_VECTOR;
                            pc_load               <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (deb_fall && !deb_level) begin
                            state   <= S_POWER_UP;
                            pwr_cnt <= '0;
                        end
                    end
                    default: state <= S_POWER_UP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench with an elapsed-time behavioural model
module tb_reset_sequencer;

    localparam int D = 4;
    localparam int P = 8;
    localparam int N = 2;
    localparam logic [15:0] ROM = 16'h0000;
    localparam logic [15:0] RAM = 16'h8000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_button = 1'b0;
    logic        boot_sel = 1'b0;
    logic        ram_switch_req = 1'b0;
    logic [15:0] pc;
    logic        pc_load;
    logic [N-1:0] domain_reset;
    logic        is_powered_on;
    logic        flag_execute_from_ram;
    logic [7:0]  reset_count;

    always #5 clk = ~clk;

    reset_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .POWER_UP_CYCLES(P),
        .NUM_DOMAINS    (N),
        .PC_WIDTH       (16),
        .ROM_VECTOR     (ROM),
        .RAM_VECTOR     (RAM)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .reset_button         (reset_button),
        .boot_sel             (boot_sel),
        .ram_switch_req       (ram_switch_req),
        .pc                   (pc),
        .pc_load              (pc_load),
        .domain_reset         (domain_reset),
        .is_powered_on        (is_powered_on),
        .flag_execute_from_ram(flag_execute_from_ram),
        .reset_count          (reset_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: outputs follow from edges elapsed since the sequence started and
    // from the raw button history delayed by the synchroniser.
    int          cyc = 0;
    int          seq_start = 0;
    int          hist[$];
    int          m_level = 0;
    bit          m_valid = 0;
    bit          m_hold = 0;
    bit          rise_prev = 0;
    bit          fall_prev = 0;
    logic [15:0] m_pc = ROM;
    logic        m_pcl = 0;
    logic        m_pow = 0;
    logic        m_flag = 0;
    logic [N-1:0] m_dom = '1;
    int          m_cnt = 0;

    initial begin
        int  e;
        bit  all_diff;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_valid   = 1;
                m_hold    = 0;
                seq_start = cyc;
                m_pc      = ROM;
                m_pcl     = 0;
                m_pow     = 0;
                m_flag    = 0;
                m_dom     = '1;
                m_cnt     = 0;
                m_level   = 0;
                rise_prev = 0;
                fall_prev = 0;
                hist      = {};
                repeat (D + 2) hist.push_back(0);
            end else if (m_valid) begin
                e     = cyc - seq_start;
                m_pcl = 0;
                if (rise_prev && !m_hold) begin
                    m_hold = 1;
                    if (m_cnt < 255) m_cnt++;
                    m_dom  = '1;
                    m_pow  = 0;
                    m_flag = 0;
                    m_pc   = ROM;
                end else if (m_hold) begin
                    if (fall_prev) begin
                        m_hold    = 0;
                        seq_start = cyc;
                    end
                end else begin
                    if (e == P) begin
                        m_flag = boot_sel;
                        m_pc   = boot_sel ? RAM : ROM;
                    end
                    for (int k = 0; k < N; k++) m_dom[k] = (e >= P + 1 + k) ? 1'b0 : 1'b1;
                    if (e == P + N) begin
                        m_pow = 1;
                        m_pcl = 1;
                    end
                    if (e > P + N && ram_switch_req && !m_flag) begin
                        m_flag = 1;
                        m_pc   = RAM;
                        m_pcl  = 1;
                    end
                end
                hist.push_back(int'(reset_button));
                if (hist.size() > D + 8) void'(hist.pop_front());
                all_diff = 1;
                for (int j = 2; j <= D + 1; j++)
                    if (hist[hist.size() - 1 - j] == m_level) all_diff = 0;
                rise_prev = all_diff && (m_level == 0);
                fall_prev = all_diff && (m_level == 1);
                if (all_diff) m_level = 1 - m_level;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("model_pc", 32'(pc), 32'(m_pc));
                check("model_pc_load", 32'(pc_load), 32'(m_pcl));
                check("model_domain_reset", 32'(domain_reset), 32'(m_dom));
                check("model_is_powered_on", 32'(is_powered_on), 32'(m_pow));
                check("model_flag", 32'(flag_execute_from_ram), 32'(m_flag));
                check("model_reset_count", 32'(reset_count), 32'(m_cnt));
            end
        end
    end

    initial begin
        int n;
        // Cold boot from ROM
        reset = 1; boot_sel = 0;
        ticks(3);
        check("reset_dom", 32'(domain_reset), 32'h3);
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_pow", 32'(is_powered_on), 32'h0);
        reset = 0;
        ticks(8);
        check("rom_e8_dom", 32'(domain_reset), 32'h3);
        ticks(1);
        check("rom_e9_dom", 32'(domain_reset), 32'h2);
        check("rom_e9_pow", 32'(is_powered_on), 32'h0);
        ticks(1);
        check("rom_e10_dom", 32'(domain_reset), 32'h0);
        check("rom_e10_pow", 32'(is_powered_on), 32'h1);
        check("rom_e10_pcl", 32'(pc_load), 32'h1);
        check("rom_e10_pc", 32'(pc), 32'h0000);
        ticks(1);
        check("rom_e11_pcl", 32'(pc_load), 32'h0);

        // Cold boot from RAM
        reset = 1; boot_sel = 1;
        ticks(3);
        reset = 0;
        ticks(7);
        check("ram_e7_flag", 32'(flag_execute_from_ram), 32'h0);
        ticks(1);
        check("ram_e8_flag", 32'(flag_execute_from_ram), 32'h1);
        check("ram_e8_pc", 32'(pc), 32'h8000);
        ticks(1);
        check("ram_e9_pow", 32'(is_powered_on), 32'h0);
        ticks(1);
        check("ram_e10_pow", 32'(is_powered_on), 32'h1);
        boot_sel = 0;
        ticks(3);

        // Glitch shorter than the debounce window
        reset_button = 1;
        ticks(3);
        reset_button = 0;
        ticks(10);
        check("glitch_pow", 32'(is_powered_on), 32'h1);
        check("glitch_count", 32'(reset_count), 32'h0);

        // Held button: HOLD seven edges after the raw rise
        reset_button = 1;
        ticks(6);
        check("btn_e6_pow", 32'(is_powered_on), 32'h1);
        ticks(1);
        check("btn_e7_pow", 32'(is_powered_on), 32'h0);
        check("btn_e7_dom", 32'(domain_reset), 32'h3);
        check("btn_e7_count", 32'(reset_count), 32'h1);
        check("btn_e7_pc", 32'(pc), 32'h0000);
        ticks(13);
        reset_button = 0;
        ticks(16);
        check("btn_rel_e36_pow", 32'(is_powered_on), 32'h0);
        ticks(1);
        check("btn_rel_e37_pow", 32'(is_powered_on), 32'h1);
        check("btn_rel_e37_pcl", 32'(pc_load), 32'h1);
        ticks(2);

        // Runtime switch to RAM, then a repeated request
        ram_switch_req = 1;
        ticks(1);
        ram_switch_req = 0;
        check("sw_flag", 32'(flag_execute_from_ram), 32'h1);
        check("sw_pc", 32'(pc), 32'h8000);
        check("sw_pcl", 32'(pc_load), 32'h1);
        ticks(1);
        check("sw_pcl_drop", 32'(pc_load), 32'h0);
        ram_switch_req = 1;
        ticks(1);
        ram_switch_req = 0;
        check("sw_again_pcl", 32'(pc_load), 32'h0);
        ticks(2);

        // Debounced rise coincident with a switch request
        reset = 1;
        ticks(2);
        reset = 0;
        ticks(12);
        reset_button = 1;
        ticks(6);
        ram_switch_req = 1;
        ticks(1);
        ram_switch_req = 0;
        reset_button = 0;
        check("coll_pow", 32'(is_powered_on), 32'h0);
        check("coll_flag", 32'(flag_execute_from_ram), 32'h0);
        check("coll_pcl", 32'(pc_load), 32'h0);

        // Reset asserted mid-RELEASE clears everything including the count
        n = 0;
        while (domain_reset !== 2'b10 && n < 100) begin
            ticks(1);
            n++;
        end
        check("release_reached", 32'(n < 100), 32'h1);
        check("pre_reset_count", 32'(reset_count), 32'h1);
        reset = 1;
        ticks(1);
        check("mid_reset_dom", 32'(domain_reset), 32'h3);
        check("mid_reset_count", 32'(reset_count), 32'h0);
        check("mid_reset_pcl", 32'(pc_load), 32'h0);
        check("mid_reset_flag", 32'(flag_execute_from_ram), 32'h0);
        reset = 0;

        // Repeated presses saturate the event counter
        for (int i = 0; i < 256; i++) begin
            reset_button = 1;
            ticks(8);
            reset_button = 0;
            ticks(8);
        end
        check("sat_count", 32'(reset_count), 32'd255);
        ticks(12);
        check("sat_recover_pow", 32'(is_powered_on), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
